// File: rtl/jogo_pkg.sv
// Shared definitions for the battleship game-control stage: state encoding,
// default parameters and the debounce-counter width helper.
package jogo_pkg;

  // Encoding matches the mode code expected by the 7-segment display stage.
  typedef enum logic [1:0] {
    ST_DESLIGADO  = 2'b00,
    ST_PREPARACAO = 2'b10,
    ST_ATAQUE     = 2'b11
  } estado_t;

  localparam int unsigned DEBOUNCE_CICLOS_PAD = 16;
  localparam int unsigned NUM_MAPAS_PAD       = 5;
  localparam int unsigned TAM_TABULEIRO_PAD   = 5;
  localparam int unsigned MAX_TENTATIVAS_PAD  = 10;

  function automatic int unsigned largura_cont(input int unsigned ciclos);
    return (ciclos > 1) ? $clog2(ciclos) : 1;
  endfunction

endpackage

// File: rtl/filtro_botao.sv
// Two-flop synchroniser, debounce filter and rising-edge pulse for one raw input.
module filtro_botao
  import jogo_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PAD
) (
  input  logic clock,
  input  logic reset,
  input  logic entrada,
  output logic nivel,
  output logic pulso
);

  localparam int unsigned     CNT_W   = largura_cont(DEBOUNCE_CICLOS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CICLOS - 1);

  logic             sinc1_q, sinc1_d;
  logic             sinc2_q, sinc2_d;
  logic             nivel_q, nivel_d;
  logic             pulso_q, pulso_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The count only advances while the synchronised value disagrees with the
  // filtered level; any agreement restarts it.
  always_comb begin
    sinc1_d = entrada;
    sinc2_d = sinc1_q;
    nivel_d = nivel_q;
    cnt_d   = '0;
    if (sinc2_q != nivel_q) begin
      if (cnt_q == CNT_MAX) begin
        nivel_d = sinc2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    pulso_d = nivel_d & ~nivel_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sinc1_q <= 1'b0;
      sinc2_q <= 1'b0;
      nivel_q <= 1'b0;
      pulso_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sinc1_q <= sinc1_d;
      sinc2_q <= sinc2_d;
      nivel_q <= nivel_d;
      pulso_q <= pulso_d;
      cnt_q   <= cnt_d;
    end
  end

  assign nivel = nivel_q;
  assign pulso = pulso_q;

endmodule

// File: rtl/controle_jogo.sv
// Game-control stage: input filtering, DESLIGADO/PREPARACAO/ATAQUE FSM, map
// selection, attack coordinates and shot counting for the display stage.
module controle_jogo
  import jogo_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PAD,
  parameter int unsigned NUM_MAPAS       = NUM_MAPAS_PAD,
  parameter int unsigned TAM_TABULEIRO   = TAM_TABULEIRO_PAD,
  parameter int unsigned MAX_TENTATIVAS  = MAX_TENTATIVAS_PAD
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       chave_liga,
  input  logic       btn_confirma,
  input  logic       btn_avanca,
  input  logic [5:0] chaves_coord,
  output logic       DESLIGADO,
  output logic       PREPARACAO,
  output logic       ATAQUE,
  output logic [2:0] mapa,
  output logic [2:0] coordColuna,
  output logic [2:0] coordLinha,
  output logic       coord_invalida,
  output logic       disparo,
  output logic [3:0] tentativas,
  output logic       fim_jogo
);

  localparam logic [2:0] MAPA_ULT = 3'(NUM_MAPAS - 1);
  localparam logic [3:0] TAM_LIM  = 4'(TAM_TABULEIRO);
  localparam logic [3:0] TENT_MAX = 4'(MAX_TENTATIVAS);

  logic liga_c, p_conf_c, p_av_c;
  logic liga_pulso_unused, conf_nivel_unused, av_nivel_unused;

  filtro_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_filtro_liga (
    .clock(clock), .reset(reset), .entrada(chave_liga),
    .nivel(liga_c), .pulso(liga_pulso_unused)
  );

  filtro_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_filtro_conf (
    .clock(clock), .reset(reset), .entrada(btn_confirma),
    .nivel(conf_nivel_unused), .pulso(p_conf_c)
  );

  filtro_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_filtro_av (
    .clock(clock), .reset(reset), .entrada(btn_avanca),
    .nivel(av_nivel_unused), .pulso(p_av_c)
  );

  estado_t    estado_q, estado_d;
  logic [5:0] coord_s1_q, coord_s1_d;
  logic [5:0] coord_s2_q, coord_s2_d;
  logic [2:0] mapa_q, mapa_d;
  logic [2:0] col_q, col_d;
  logic [2:0] lin_q, lin_d;
  logic       inval_q, inval_d;
  logic       disp_q, disp_d;
  logic [3:0] tent_q, tent_d;
  logic       fim_q, fim_d;
  logic       desl_q, desl_d;
  logic       prep_q, prep_d;
  logic       atq_q, atq_d;
  logic       coord_ok_c;

  // Comparison in 4 bits so a board side of 8 still works.
  assign coord_ok_c = ({1'b0, coord_s2_q[5:3]} < TAM_LIM) &&
                      ({1'b0, coord_s2_q[2:0]} < TAM_LIM);

  always_comb begin
    estado_d   = estado_q;
    coord_s1_d = chaves_coord;
    coord_s2_d = coord_s1_q;
    mapa_d     = mapa_q;
    col_d      = col_q;
    lin_d      = lin_q;
    inval_d    = inval_q;
    disp_d     = 1'b0;
    tent_d     = tent_q;
    fim_d      = fim_q;

    if (!liga_c) begin
      estado_d = ST_DESLIGADO;
      mapa_d   = '0;
      col_d    = '0;
      lin_d    = '0;
      inval_d  = 1'b0;
      tent_d   = '0;
    end else begin
      unique case (estado_q)
        ST_DESLIGADO: begin
          estado_d = ST_PREPARACAO;
          mapa_d   = '0;
          fim_d    = 1'b0;
        end
        ST_PREPARACAO: begin
          if (p_conf_c) begin
            estado_d = ST_ATAQUE;
            tent_d   = '0;
            fim_d    = 1'b0;
          end else if (p_av_c) begin
            mapa_d = (mapa_q == MAPA_ULT) ? 3'd0 : mapa_q + 3'd1;
          end
        end
        ST_ATAQUE: begin
          if (coord_ok_c) begin
            col_d   = coord_s2_q[5:3];
            lin_d   = coord_s2_q[2:0];
            inval_d = 1'b0;
          end else begin
            inval_d = 1'b1;
          end
          // Validity is judged on the value being loaded, so the coordinates
          // shown alongside disparo are the ones fired.
          if (p_conf_c && coord_ok_c) begin
            disp_d = 1'b1;
            tent_d = tent_q + 4'd1;
            if (tent_d == TENT_MAX) begin
              estado_d = ST_PREPARACAO;
              fim_d    = 1'b1;
            end
          end
        end
        default: estado_d = ST_DESLIGADO;
      endcase
    end

    desl_d = (estado_d == ST_DESLIGADO);
    prep_d = (estado_d == ST_PREPARACAO);
    atq_d  = (estado_d == ST_ATAQUE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= ST_DESLIGADO;
      coord_s1_q <= '0;
      coord_s2_q <= '0;
      mapa_q     <= '0;
      col_q      <= '0;
      lin_q      <= '0;
      inval_q    <= 1'b0;
      disp_q     <= 1'b0;
      tent_q     <= '0;
      fim_q      <= 1'b0;
      desl_q     <= 1'b1;
      prep_q     <= 1'b0;
      atq_q      <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      coord_s1_q <= coord_s1_d;
      coord_s2_q <= coord_s2_d;
      mapa_q     <= mapa_d;
      col_q      <= col_d;
      lin_q      <= lin_d;
      inval_q    <= inval_d;
      disp_q     <= disp_d;
      tent_q     <= tent_d;
      fim_q      <= fim_d;
      desl_q     <= desl_d;
      prep_q     <= prep_d;
      atq_q      <= atq_d;
    end
  end

  assign DESLIGADO      = desl_q;
  assign PREPARACAO     = prep_q;
  assign ATAQUE         = atq_q;
  assign mapa           = mapa_q;
  assign coordColuna    = col_q;
  assign coordLinha     = lin_q;
  assign coord_invalida = inval_q;
  assign disparo        = disp_q;
  assign tentativas     = tent_q;
  assign fim_jogo       = fim_q;

endmodule

// File: tb/tb_controle_jogo.sv
// Directed bench for controle_jogo with short debounce and a 3-shot round.
module tb_controle_jogo;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       chave_liga = 1'b0;
  logic       btn_confirma = 1'b0;
  logic       btn_avanca = 1'b0;
  logic [5:0] chaves_coord = 6'd0;
  logic       DESLIGADO, PREPARACAO, ATAQUE;
  logic [2:0] mapa, coordColuna, coordLinha;
  logic       coord_invalida, disparo, fim_jogo;
  logic [3:0] tentativas;

  int n_vec  = 0;
  int n_miss = 0;
  int n_disp = 0;
  logic [2:0] disp_col = 3'd0;
  logic [2:0] disp_lin = 3'd0;
  int base;
  logic [2:0] mapa_esp;

  controle_jogo #(
    .DEBOUNCE_CICLOS(4), .NUM_MAPAS(5), .TAM_TABULEIRO(5), .MAX_TENTATIVAS(3)
  ) dut (
    .clock(clock), .reset(reset), .chave_liga(chave_liga),
    .btn_confirma(btn_confirma), .btn_avanca(btn_avanca),
    .chaves_coord(chaves_coord),
    .DESLIGADO(DESLIGADO), .PREPARACAO(PREPARACAO), .ATAQUE(ATAQUE),
    .mapa(mapa), .coordColuna(coordColuna), .coordLinha(coordLinha),
    .coord_invalida(coord_invalida), .disparo(disparo),
    .tentativas(tentativas), .fim_jogo(fim_jogo)
  );

  always #5 clock = ~clock;

  // Shot log: count strobes and remember the coordinates shown with them.
  always @(negedge clock) begin
    if (disparo) begin
      n_disp   <= n_disp + 1;
      disp_col <= coordColuna;
      disp_lin <= coordLinha;
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press_conf();
    btn_confirma = 1'b1; tick(10);
    btn_confirma = 1'b0; tick(10);
  endtask

  task automatic press_av();
    btn_avanca = 1'b1; tick(10);
    btn_avanca = 1'b0; tick(10);
  endtask

  task automatic wait_prep(input string tag);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (PREPARACAO) break;
    end
    chk(tag, PREPARACAO, 1);
  endtask

  initial begin
    tick(3);
    chk("rst_desl", DESLIGADO, 1);
    chk("rst_prep", PREPARACAO, 0);
    chk("rst_atq", ATAQUE, 0);
    chk("rst_mapa", mapa, 0);
    chk("rst_col", coordColuna, 0);
    chk("rst_lin", coordLinha, 0);
    chk("rst_tent", tentativas, 0);
    chk("rst_disp", disparo, 0);
    chk("rst_inval", coord_invalida, 0);
    chk("rst_fim", fim_jogo, 0);
    reset = 1'b0;
    tick(2);

    chave_liga = 1'b1;
    wait_prep("liga_prep");
    chk("liga_desl", DESLIGADO, 0);
    chk("liga_mapa", mapa, 0);

    mapa_esp = 3'd0;
    for (int i = 0; i < 7; i++) begin
      press_av();
      mapa_esp = (mapa_esp == 3'd4) ? 3'd0 : mapa_esp + 3'd1;
      chk($sformatf("av_%0d", i), mapa, 8'(mapa_esp));
    end
    btn_avanca = 1'b1; tick(2);
    btn_avanca = 1'b0; tick(10);
    chk("glitch_mapa", mapa, 2);

    btn_confirma = 1'b1; btn_avanca = 1'b1; tick(10);
    btn_confirma = 1'b0; btn_avanca = 1'b0; tick(10);
    chk("both_atq", ATAQUE, 1);
    chk("both_mapa", mapa, 2);
    chk("both_tent", tentativas, 0);

    base = n_disp;
    chaves_coord = 6'b011_010; tick(5);
    press_conf();
    chk("shot1_col", coordColuna, 3);
    chk("shot1_lin", coordLinha, 2);
    chk("shot1_ndisp", 8'(n_disp - base), 1);
    chk("shot1_dcol", disp_col, 3);
    chk("shot1_dlin", disp_lin, 2);
    chk("shot1_tent", tentativas, 1);

    base = n_disp;
    chaves_coord = 6'b110_000; tick(5);
    chk("inval_flag", coord_invalida, 1);
    chk("inval_col", coordColuna, 3);
    chk("inval_lin", coordLinha, 2);
    press_conf();
    chk("inval_tent", tentativas, 1);
    chk("inval_ndisp", 8'(n_disp - base), 0);

    chaves_coord = 6'b001_100; tick(5);
    chk("valid_again", coord_invalida, 0);
    base = n_disp;
    press_conf();
    chk("shot2_tent", tentativas, 2);
    press_conf();
    chk("end_prep", PREPARACAO, 1);
    chk("end_atq", ATAQUE, 0);
    chk("end_fim", fim_jogo, 1);
    chk("end_tent", tentativas, 3);
    chk("end_mapa", mapa, 2);
    chk("end_ndisp", 8'(n_disp - base), 2);
    chk("end_dcol", disp_col, 1);
    chk("end_dlin", disp_lin, 4);

    press_conf();
    chk("new_atq", ATAQUE, 1);
    chk("new_tent", tentativas, 0);
    chk("new_fim", fim_jogo, 0);
    press_conf();
    chk("new_shot", tentativas, 1);

    base = n_disp;
    chave_liga = 1'b0; btn_confirma = 1'b1; tick(10);
    btn_confirma = 1'b0; tick(5);
    chk("off_desl", DESLIGADO, 1);
    chk("off_ndisp", 8'(n_disp - base), 0);
    chk("off_tent", tentativas, 0);
    chk("off_mapa", mapa, 0);
    chk("off_col", coordColuna, 0);

    chave_liga = 1'b1;
    wait_prep("reon_prep");
    press_conf();
    press_conf();
    chk("reon_tent", tentativas, 1);
    reset = 1'b1;
    tick(1);
    chk("mrst_desl", DESLIGADO, 1);
    chk("mrst_atq", ATAQUE, 0);
    chk("mrst_tent", tentativas, 0);
    chk("mrst_disp", disparo, 0);
    reset = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
